cycdelay_drive: RTL and testbench

//  Drive side of clocking-block stimulus: turns a stream of (value, cycle-delay)

---
 rtl/cycdelay_pkg.sv | 12 +
 rtl/cycdelay_fifo.sv | 47 ++++
 rtl/cycdelay_drive.sv | 133 +++++++++++++
 tb/tb_cycdelay_drive.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cycdelay_pkg.sv
// Shared types for the cycle-delay drive sequencer: request record and slot FSM states.
package cycdelay_pkg;
  localparam int WIDTH = 8;
  localparam int DLY_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [DLY_W-1:0] dly;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_e;
endpackage

// File: rtl/cycdelay_fifo.sv
// Request FIFO ahead of the active slot; power-of-2 depth with naturally wrapping pointers.
module cycdelay_fifo
  import cycdelay_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  req_t                   wdata,
  output req_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/cycdelay_drive.sv
// "##N sig <= value" sequencer: FIFO -> active slot with down-counter -> output stages.
// Each request's delay counts from the previous commit, so spacing is dly+1 cycles.
module cycdelay_drive
  import cycdelay_pkg::*;
#(
  parameter int               DEPTH      = 4,
  parameter int               OUT_STAGES = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [DLY_W-1:0] req_dly,
  input  logic             abort,
  output logic [WIDTH-1:0] drv_q,
  output logic             drv_strobe,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  req_t             slot_q, slot_d;
  logic             ready_q, ready_d;

  req_t             req, fifo_rdata;
  logic             accept, load, commit, push, pop, bypass;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count, fifo_cnt_d;

  logic [OUT_STAGES-1:0][WIDTH-1:0] pd_q;
  logic [OUT_STAGES-1:0]            ps_q;

  assign req.data  = req_data;
  assign req.dly   = req_dly;
  assign req_ready = ready_q && !abort;
  assign accept    = req_valid && req_ready;

  cycdelay_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (abort),
    .push  (push),
    .pop   (pop),
    .wdata (req),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    load    = 1'b0;
    commit  = 1'b0;
    pop     = 1'b0;
    bypass  = 1'b0;
    case (state_q)
      IDLE:   load = 1'b1;
      WAIT: begin
        cnt_d = cnt_q - DLY_W'(1);
        if (cnt_q == DLY_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        commit = 1'b1;
        load   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Reload in the same edge as a commit keeps dly=0 streams bubble-free.
    if (load) begin
      if (!fifo_empty) begin
        pop    = 1'b1;
        slot_d = fifo_rdata;
      end else if (accept) begin
        bypass = 1'b1;
        slot_d = req;
      end
      if (!fifo_empty || accept) begin
        cnt_d   = slot_d.dly;
        state_d = (slot_d.dly == '0) ? COMMIT : WAIT;
      end else begin
        state_d = IDLE;
      end
    end
    push = accept && !bypass && !fifo_full;
    if (abort) begin
      state_d = IDLE;
      commit  = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
    end
    fifo_cnt_d = abort ? '0 : fifo_count + CW'(push) - CW'(pop);
    ready_d    = !((state_d != IDLE) && (fifo_cnt_d == CW'(DEPTH)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      ready_q <= ready_d;
    end
  end

  // Each stage only captures when a strobe arrives, so drv_q holds between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_STAGES; i++) pd_q[i] <= RESET_VAL;
      ps_q <= '0;
    end else begin
      ps_q[0] <= commit;
      if (commit) pd_q[0] <= slot_q.data;
      for (int i = 1; i < OUT_STAGES; i++) begin
        ps_q[i] <= ps_q[i-1];
        if (ps_q[i-1]) pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign drv_q      = pd_q[OUT_STAGES-1];
  assign drv_strobe = ps_q[OUT_STAGES-1];
  assign busy       = (state_q != IDLE) || !fifo_empty || (|ps_q);
endmodule

// File: tb/tb_cycdelay_drive.sv
// Randomised + directed bench; two instances (OUT_STAGES 1 and 3) share stimulus and
// are checked against a commit-time model: commit = max(accept, prev commit) + 1 + dly.
module tb_cycdelay_drive;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, req_valid, abort;
  logic [7:0] req_data;
  logic [3:0] req_dly;
  logic [7:0] drv [2];
  logic       stb [2], bsy [2], rdy [2];

  always #5 clk = ~clk;

  cycdelay_drive #(.DEPTH(DEPTH), .OUT_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_data(req_data), .req_dly(req_dly), .abort(abort),
    .drv_q(drv[0]), .drv_strobe(stb[0]), .busy(bsy[0]));

  cycdelay_drive #(.DEPTH(DEPTH), .OUT_STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_data(req_data), .req_dly(req_dly), .abort(abort),
    .drv_q(drv[1]), .drv_strobe(stb[1]), .busy(bsy[1]));

  typedef struct {
    logic [7:0] data;
    int         commit_e;
    int         vis_e;
  } pend_t;

  pend_t      sb [2][$];
  logic [7:0] exp_drv [2];
  int         edge_n = 0, c_prev = 0;
  bit         rst_flag = 1'b0, mon_on = 1'b0, acc = 1'b0;
  int         n_vec = 0, n_bad = 0;

  function automatic int os_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [os=%0d] edge %0d: got %0h, want %0h", nm, os_of(inst), edge_n, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sb[i].delete();
        exp_drv[i] = 8'h00;
      end
      c_prev   = 0;
      rst_flag = 1'b1;
    end else begin
      rst_flag = 1'b0;
      if (abort) begin
        for (int i = 0; i < 2; i++)
          for (int j = sb[i].size() - 1; j >= 0; j--)
            if (sb[i][j].commit_e >= edge_n) sb[i].delete(j);
        c_prev = 0;
      end
      if (acc) begin
        int l, c;
        l = (edge_n > c_prev) ? edge_n : c_prev;
        c = l + 1 + int'(req_dly);
        for (int i = 0; i < 2; i++)
          sb[i].push_back('{data: req_data, commit_e: c, vis_e: c + os_of(i) - 1});
        c_prev = c;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    acc = req_valid && (rdy[0] === 1'b1) && !rst;
    @(posedge clk);
    edge_n++;
    model_update();
    mon_on = 1'b1;
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] dl,
                       input logic ab, input logic r);
    req_valid = v;
    req_data  = d;
    req_dly   = dl;
    abort     = ab;
    rst       = r;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard when a strobe is due and checks every output each cycle.
  int         m_occ;
  bit         m_stb, m_busy, m_rdy;
  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        m_occ = 0;
        for (int j = 0; j < sb[i].size(); j++)
          if (sb[i][j].commit_e > edge_n) m_occ++;
        m_rdy = !rst_flag && !abort && (m_occ < DEPTH + 1);
        while (sb[i].size() != 0 && sb[i][0].vis_e < edge_n) begin
          chk("strobe_missed", i, 32'd0, 32'd1);
          void'(sb[i].pop_front());
        end
        m_busy = (sb[i].size() != 0);
        m_stb  = (sb[i].size() != 0) && (sb[i][0].vis_e == edge_n);
        if (m_stb) exp_drv[i] = sb[i].pop_front().data;
        chk("drv_strobe", i, 32'(stb[i]), 32'(m_stb));
        chk("drv_q", i, 32'(drv[i]), 32'(exp_drv[i]));
        chk("busy", i, 32'(bsy[i]), 32'(m_busy));
        chk("req_ready", i, 32'(rdy[i]), 32'(m_rdy));
      end
    end
  end

  initial begin
    int cnt, first_e, sixth_e;
    req_valid = 1'b0; req_data = '0; req_dly = '0; abort = 1'b0; rst = 1'b1;
    exp_drv[0] = 8'h00; exp_drv[1] = 8'h00;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    // quiet after reset
    idle(20);
    // dly=0 walking ones, one per cycle
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(16'd1 << i), 4'd0, 1'b0, 1'b0);
    idle(6);
    // single delayed request
    drive(1'b1, 8'hA5, 4'd3, 1'b0, 1'b0);
    idle(10);
    // fill with long delays; sixth accept must follow the first commit
    cnt = 0; first_e = -1; sixth_e = -1;
    for (int t = 0; t < 80 && cnt < 6; t++) begin
      drive(1'b1, 8'h40 + 8'(cnt), 4'd15, 1'b0, 1'b0);
      if (acc) begin
        cnt++;
        if (cnt == 1) first_e = edge_n;
        if (cnt == 6) sixth_e = edge_n;
      end
    end
    chk("fill_accepts", 0, 32'(cnt), 32'd6);
    chk("fill_6th_edge", 0, 32'(sixth_e), 32'(first_e + 17));
    // abort mid-wait with a queue behind it, request held during the abort
    idle(4);
    drive(1'b1, 8'h77, 4'd0, 1'b1, 1'b0);
    idle(6);
    drive(1'b1, 8'h3C, 4'd0, 1'b0, 1'b0);
    idle(6);
    // reset in the middle of a back-to-back stream
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h90 + 8'(i), 4'd0, 1'b0, (i == 5));
    idle(8);
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(16'd1 << i), 4'd0, 1'b0, 1'b0);
    idle(8);
    // random traffic with occasional abort / reset
    for (int t = 0; t < 600; t++) begin
      drive(($urandom % 3) != 0, 8'($urandom),
            (($urandom % 8) == 0) ? 4'($urandom % 16) : 4'($urandom % 3),
            ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    idle(100);
    chk("drained", 0, 32'(sb[0].size()), 32'd0);
    chk("drained", 1, 32'(sb[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
